trace_capture_ctrl: RTL and testbench
=====================================

Name: trace_capture_ctrl

Overview:
- Sequences on-chip trace capture for the pipeline debug path.
- Records one probe word per retired instruction into a circular buffer, and holds pre-trigger history.
- Fires on a PC match or a forced trigger, then collects a programmable number of post-trigger samples.
- Freezes the buffer and streams it out oldest-first over a valid/ready port. Arms only while the clock wizard reports lock.

Parameters:
- DATA_W, 32, width of one captured probe word
- DEPTH, 256, buffer entries; power of two, at least 4
- ADDR_W, $clog2(DEPTH), buffer index width

Ports:
- clk  in  1  core clock (clk_out1 of the clock wizard)
- rst_n  in  1  synchronous active-low reset
- locked_i  in  1  clock wizard lock indicator
- arm_i  in  1  one-cycle pulse; starts a capture from IDLE
- pc_valid_i  in  1  retire strobe; a sample is taken this cycle
- pc_i  in  32  retiring PC
- sample_i  in  DATA_W  probe word written with each sample
- trig_pc_i  in  32  PC match value
- trig_force_i  in  1  immediate trigger, qualified by pc_valid_i
- post_cnt_i  in  ADDR_W+1  post-trigger samples including the trigger sample; sampled at arm; 0 is treated as 1; clamped to DEPTH
- rd_valid_o  out  1  read data valid
- rd_data_o  out  DATA_W  read data
- rd_last_o  out  1  final entry of the dump
- rd_ready_i  in  1  consumer accept
- state_o  out  2  0=IDLE, 1=ARMED, 2=POST, 3=READ
- triggered_o  out  1  sticky; set at trigger, cleared at next arm or on reset

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE; wr_ptr, fill count, post counter and read pointer cleared.
  - rd_valid_o=0, rd_last_o=0, rd_data_o=0, triggered_o=0.
  - Buffer contents are don't-care.
- IDLE -> ARMED on arm_i & locked_i.
  - Latch post_cnt_i; clear wr_ptr, fill count and triggered_o.
  - arm_i without locked_i is ignored. arm_i outside IDLE is ignored.
- ARMED:
  - Each pc_valid_i cycle writes sample_i at wr_ptr, increments wr_ptr (wraps at DEPTH), and increments fill count (saturates at DEPTH).
  - Trigger = pc_valid_i & (pc_i==trig_pc_i | trig_force_i).
  - The trigger sample is written in that same cycle and counts as post sample 1.
  - On trigger, set triggered_o. If the latched count is 1, go to READ; otherwise go to POST with remaining = latched count - 1.
- POST:
  - Each pc_valid_i writes and decrements remaining. Further triggers are ignored.
  - When remaining reaches 0 after a write, go to READ next cycle.
  - Post samples overwrite the oldest pre-trigger history when the buffer is full.
- READ: the buffer is frozen and no writes occur.
  - start = (fill==DEPTH) ? wr_ptr : 0; length = fill.
  - Cycle 1 after entry is a prefetch: rd_valid_o=0.
  - From cycle 2, rd_valid_o=1 with entry[start].
  - rd_data_o and rd_last_o hold stable while rd_valid_o & !rd_ready_i.
  - On each handshake, the next entry (index wraps modulo DEPTH) is presented the following cycle with no bubble. The buffer uses a registered read with a one-entry lookahead.
  - rd_last_o=1 on entry length-1.
  - The handshake on the last entry returns the block to IDLE; rd_valid_o=0 the next cycle.
- Loss of lock: locked_i low in ARMED, POST or READ aborts to IDLE on the next edge.
  - rd_valid_o drops and the dump is truncated without rd_last_o.
  - triggered_o is kept.
- Reset mid-operation: same as reset; no partial dump.
- A simultaneous pc_valid_i and abort is not written.
- A trigger on the same cycle as arm is not possible, since arm only moves the block to ARMED.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - A 16-bit free-running cycle counter runs from reset and wraps.
  - Its value is stored alongside every written sample.
  - Extra output rd_ts_o[15:0] is presented and held with rd_data_o under the same valid/ready rules; it is 0 at reset.
- Undefined: no counter, no timestamp storage, no rd_ts_o port.

Test Plan:
- Lock gating: locked_i=0, arm_i pulse -> state_o stays 0. Set locked_i=1, pulse arm_i -> state_o=1 next cycle.
- Short capture: DEPTH=256, post_cnt_i=4, 10 retires with sample_i=PC (0x0..0x24), trig_pc_i=0x14.
  - Expect triggered_o=1 at PC 0x14 and READ after PC 0x20.
  - Dump is 9 words, 0x0..0x20, rd_last_o on 0x20.
- Wrap: DEPTH=8, post_cnt_i=3, 20 retires 0..19, force trigger at sample 12 -> dump of 8 words 7..14 oldest-first, last=14.
- Backpressure: toggle rd_ready_i 1/0 each cycle during the dump -> no word dropped or duplicated; data and last stable while stalled; IDLE after the final handshake.
- Abort: drop locked_i during POST -> state_o=0 next cycle, rd_valid_o=0, triggered_o remains 1. Re-arm -> triggered_o=0.
- Timestamp (TRACE_TIMESTAMP_EN): retires on cycles N, N+3, N+4 -> rd_ts_o differences are 3 then 1, with correct wrap at 0xFFFF->0x0000.

Source files
------------

// File: rtl/trace_capture_ctrl_if.sv
// Trace dump read port: valid/ready stream of captured probe words.
// With TRACE_TIMESTAMP_EN defined the port also carries a 16-bit timestamp.
interface trace_capture_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_last_o;
  logic              rd_ready_i;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]       rd_ts_o;
`endif

  modport master (
    output rd_valid_o,
    output rd_data_o,
    output rd_last_o,
`ifdef TRACE_TIMESTAMP_EN
    output rd_ts_o,
`endif
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o,
    input  rd_data_o,
    input  rd_last_o,
`ifdef TRACE_TIMESTAMP_EN
    input  rd_ts_o,
`endif
    output rd_ready_i
  );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: circular pre/post-trigger buffer, oldest-first dump.
// Optional TRACE_TIMESTAMP_EN stores a free-running 16-bit cycle stamp per sample.
module trace_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked_i,
  input  logic                arm_i,
  input  logic                pc_valid_i,
  input  logic [31:0]         pc_i,
  input  logic [DATA_W-1:0]   sample_i,
  input  logic [31:0]         trig_pc_i,
  input  logic                trig_force_i,
  input  logic [ADDR_W:0]     post_cnt_i,
  trace_capture_ctrl_if.master rd,
  output logic [1:0]          state_o,
  output logic                triggered_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  function automatic logic [ADDR_W:0] post_norm(input logic [ADDR_W:0] n);
    if (n == '0)  return ONE;
    if (n > FULL) return FULL;
    return n;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     fill_q;
  logic [ADDR_W:0]     post_len_q;
  logic [ADDR_W:0]     remain_q;
  logic                triggered_q;
  logic [ADDR_W-1:0]   rd_idx_q;
  logic [ADDR_W:0]     rd_cnt_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                trig_hit;
  logic                wr_en;
  logic                hs;
  logic                rd_load;
  logic                rd_first;
  logic [ADDR_W-1:0]   rd_start;
  logic [ADDR_W-1:0]   rd_addr;
  logic                last_nxt;

  // Read output stage: registered buffer read presented on the port
  logic                vld_p0;
  logic [DATA_W-1:0]   rd_data_p0;
  logic                last_p0;

  assign trig_hit = pc_valid_i && ((pc_i == trig_pc_i) || trig_force_i);
  assign wr_en    = pc_valid_i && locked_i &&
                    ((state_q == S_ARMED) || (state_q == S_POST));
  assign hs       = vld_p0 && rd.rd_ready_i;

  // When the buffer has wrapped, the oldest entry sits at the write pointer.
  assign rd_start = (fill_q == FULL) ? wr_ptr_q : '0;
  assign rd_first = !vld_p0;
  assign rd_addr  = rd_first ? rd_start : (rd_idx_q + ADDR_W'(1));
  assign rd_load  = (state_q == S_READ) && locked_i &&
                    (rd_first || (hs && !last_p0));
  assign last_nxt = rd_first ? (fill_q == ONE) : ((rd_cnt_q + ONE) == fill_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm_i && locked_i) state_d = S_ARMED;
      S_ARMED: begin
        if (!locked_i)     state_d = S_IDLE;
        else if (trig_hit) state_d = (post_len_q == ONE) ? S_READ : S_POST;
      end
      S_POST: begin
        if (!locked_i)                             state_d = S_IDLE;
        else if (pc_valid_i && (remain_q == ONE))  state_d = S_READ;
      end
      S_READ: begin
        if (!locked_i)          state_d = S_IDLE;
        else if (hs && last_p0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_len_q  <= ONE;
      remain_q    <= '0;
      triggered_q <= 1'b0;
      rd_idx_q    <= '0;
      rd_cnt_q    <= '0;
      vld_p0      <= 1'b0;
      last_p0     <= 1'b0;
      rd_data_p0  <= '0;
    end else begin
      state_q <= state_d;

      if ((state_q == S_IDLE) && arm_i && locked_i) begin
        post_len_q  <= post_norm(post_cnt_i);
        wr_ptr_q    <= '0;
        fill_q      <= '0;
        triggered_q <= 1'b0;
      end

      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (fill_q != FULL) fill_q <= fill_q + ONE;
      end

      // The trigger sample itself is post sample 1.
      if ((state_q == S_ARMED) && locked_i && trig_hit) begin
        triggered_q <= 1'b1;
        remain_q    <= post_len_q - ONE;
      end else if ((state_q == S_POST) && wr_en) begin
        remain_q <= remain_q - ONE;
      end

      if (state_d != S_READ) begin
        vld_p0  <= 1'b0;
        last_p0 <= 1'b0;
      end else if (rd_load) begin
        vld_p0     <= 1'b1;
        last_p0    <= last_nxt;
        rd_data_p0 <= mem[rd_addr];
        rd_idx_q   <= rd_addr;
        rd_cnt_q   <= rd_first ? ONE : (rd_cnt_q + ONE);
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_mem [DEPTH];
  logic [15:0] ts_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr_q] <= ts_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                            ts_p0 <= '0;
    else if ((state_d == S_READ) && rd_load) ts_p0 <= ts_mem[rd_addr];
  end

  assign rd.rd_ts_o = ts_p0;
`endif

  assign rd.rd_valid_o = vld_p0;
  assign rd.rd_data_o  = rd_data_p0;
  assign rd.rd_last_o  = last_p0;
  assign state_o       = state_q;
  assign triggered_o   = triggered_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Scoreboard bench for trace_capture_ctrl: DEPTH=256 and DEPTH=8 instances.
// Expected dump words are queued as stimulus is driven and popped on each handshake.
module tb_trace_capture_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] ts;
    bit          chk_ts;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b0;
  logic        arm_a = 1'b0, arm_b = 1'b0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0, sample = '0, trig_pc = '0;
  logic        trig_force = 1'b0;
  logic [8:0]  post_a = '0;
  logic [3:0]  post_b = '0;
  logic        rd_ready = 1'b1;
  int          rdy_mode = 0;
  logic [1:0]  state_a, state_b;
  logic        trig_a, trig_b;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  exp_t        q_a[$], q_b[$];
  exp_t        e_a, e_b;
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [31:0] hold_d_a = '0, hold_d_b = '0;
  logic        hold_l_a = 1'b0, hold_l_b = 1'b0;
  logic [15:0] ts_seen_a = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trace_capture_ctrl_if #(.DATA_W(32)) if_a ();
  trace_capture_ctrl_if #(.DATA_W(32)) if_b ();
  assign if_a.rd_ready_i = rd_ready;
  assign if_b.rd_ready_i = rd_ready;

  trace_capture_ctrl #(.DATA_W(32), .DEPTH(256)) u_a (
    .clk(clk), .rst_n(rst_n), .locked_i(locked), .arm_i(arm_a),
    .pc_valid_i(pc_valid), .pc_i(pc), .sample_i(sample), .trig_pc_i(trig_pc),
    .trig_force_i(trig_force), .post_cnt_i(post_a), .rd(if_a.master),
    .state_o(state_a), .triggered_o(trig_a)
  );

  trace_capture_ctrl #(.DATA_W(32), .DEPTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .locked_i(locked), .arm_i(arm_b),
    .pc_valid_i(pc_valid), .pc_i(pc), .sample_i(sample), .trig_pc_i(trig_pc),
    .trig_force_i(trig_force), .post_cnt_i(post_b), .rd(if_b.master),
    .state_o(state_b), .triggered_o(trig_b)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit b, input logic [31:0] d, input bit l,
                          input logic [15:0] ts = 16'h0, input bit ct = 1'b0);
    exp_t e;
    e.data = d; e.last = l; e.ts = ts; e.chk_ts = ct;
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] s, input logic f);
    pc_valid = 1'b1; pc = p; sample = s; trig_force = f;
    tick();
    pc_valid = 1'b0; trig_force = 1'b0;
  endtask

  task automatic arm(input bit b);
    if (b) arm_b = 1'b1; else arm_a = 1'b1;
    tick();
    arm_a = 1'b0; arm_b = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit b);
    int n = 0;
    while (((b ? state_b : state_a) != 2'd0) && (n < 300)) begin
      tick();
      n++;
    end
    chk_eq({tag, "_idle"}, b ? state_b : state_a, 0);
    tick();
    chk_eq({tag, "_vld_low"}, b ? if_b.rd_valid_o : if_a.rd_valid_o, 0);
    chk_eq({tag, "_drained"}, b ? q_b.size() : q_a.size(), 0);
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      default: rd_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && if_a.rd_valid_o) begin
      if (stall_a) begin
        chk_eq("a_hold_data", if_a.rd_data_o, hold_d_a);
        chk_eq("a_hold_last", if_a.rd_last_o, hold_l_a);
      end
      if (if_a.rd_ready_i) begin
        chk_eq("a_word_expected", 32'(q_a.size() != 0), 1);
        if (q_a.size() != 0) begin
          e_a = q_a.pop_front();
          chk_eq("a_data", if_a.rd_data_o, e_a.data);
          chk_eq("a_last", if_a.rd_last_o, e_a.last);
`ifdef TRACE_TIMESTAMP_EN
          ts_seen_a <= if_a.rd_ts_o;
          if (e_a.chk_ts) chk_eq("a_ts", if_a.rd_ts_o, e_a.ts);
`endif
        end
      end
    end
    stall_a  <= rst_n && if_a.rd_valid_o && !if_a.rd_ready_i;
    hold_d_a <= if_a.rd_data_o;
    hold_l_a <= if_a.rd_last_o;
  end

  always @(negedge clk) begin
    if (rst_n && if_b.rd_valid_o) begin
      if (stall_b) begin
        chk_eq("b_hold_data", if_b.rd_data_o, hold_d_b);
        chk_eq("b_hold_last", if_b.rd_last_o, hold_l_b);
      end
      if (if_b.rd_ready_i) begin
        chk_eq("b_word_expected", 32'(q_b.size() != 0), 1);
        if (q_b.size() != 0) begin
          e_b = q_b.pop_front();
          chk_eq("b_data", if_b.rd_data_o, e_b.data);
          chk_eq("b_last", if_b.rd_last_o, e_b.last);
        end
      end
    end
    stall_b  <= rst_n && if_b.rd_valid_o && !if_b.rd_ready_i;
    hold_d_b <= if_b.rd_data_o;
    hold_l_b <= if_b.rd_last_o;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) tick();
    chk_eq("rst_state_a", state_a, 0);
    chk_eq("rst_state_b", state_b, 0);
    chk_eq("rst_valid", if_a.rd_valid_o, 0);
    chk_eq("rst_data", if_a.rd_data_o, 0);
    chk_eq("rst_last", if_a.rd_last_o, 0);
    chk_eq("rst_trig", trig_a, 0);
`ifdef TRACE_TIMESTAMP_EN
    chk_eq("rst_ts", if_a.rd_ts_o, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Lock gating
    post_a = 9'd4;
    arm(1'b0);
    chk_eq("arm_unlocked", state_a, 0);
    locked = 1'b1;
    tick();
    arm(1'b0);
    chk_eq("arm_locked", state_a, 1);

    // Short capture on PC match
    trig_pc = 32'h14;
    for (int i = 0; i <= 8; i++) push_exp(1'b0, 32'(4 * i), i == 8);
    for (int i = 0; i <= 9; i++) begin
      retire(32'(4 * i), 32'(4 * i), 1'b0);
      if (i == 4) chk_eq("short_pre_trig", trig_a, 0);
      if (i == 5) begin
        chk_eq("short_trig", trig_a, 1);
        chk_eq("short_post", state_a, 2);
      end
      if (i == 8) begin
        chk_eq("short_read", state_a, 3);
        chk_eq("short_prefetch", if_a.rd_valid_o, 0);
      end
    end
    wait_idle("short", 1'b0);

    // Wrap on DEPTH=8 with backpressure
    trig_pc = 32'hFFFF_FFFF;
    post_b = 4'd3;
    arm(1'b1);
    rdy_mode = 1;
    for (int i = 7; i <= 14; i++) push_exp(1'b1, 32'(i), i == 14);
    for (int i = 0; i < 20; i++) begin
      retire(32'(i), 32'(i), i == 12);
      if (i == 14) chk_eq("wrap_read", state_b, 3);
    end
    wait_idle("wrap", 1'b1);
    rdy_mode = 0;

    // post count 0 behaves as 1
    post_b = 4'd0;
    arm(1'b1);
    push_exp(1'b1, 32'd100, 1'b0);
    push_exp(1'b1, 32'd101, 1'b0);
    push_exp(1'b1, 32'd102, 1'b1);
    retire(32'd100, 32'd100, 1'b0);
    retire(32'd101, 32'd101, 1'b0);
    retire(32'd102, 32'd102, 1'b1);
    chk_eq("post0_read", state_b, 3);
    wait_idle("post0", 1'b1);

    // post count above DEPTH clamps to DEPTH
    post_b = 4'd15;
    arm(1'b1);
    for (int i = 202; i <= 209; i++) push_exp(1'b1, 32'(i), i == 209);
    for (int i = 200; i <= 209; i++) begin
      retire(32'(i), 32'(i), i == 202);
      if (i == 208) chk_eq("clamp_post", state_b, 2);
      if (i == 209) chk_eq("clamp_read", state_b, 3);
    end
    wait_idle("clamp", 1'b1);

    // Lock loss during READ truncates the dump
    rdy_mode = 2;
    post_a = 9'd1;
    arm(1'b0);
    retire(32'h60, 32'h60, 1'b1);
    tick();
    chk_eq("trunc_valid", if_a.rd_valid_o, 1);
    chk_eq("trunc_data", if_a.rd_data_o, 32'h60);
    chk_eq("trunc_last", if_a.rd_last_o, 1);
    locked = 1'b0;
    tick();
    chk_eq("trunc_state", state_a, 0);
    chk_eq("trunc_valid_low", if_a.rd_valid_o, 0);
    chk_eq("trunc_last_low", if_a.rd_last_o, 0);
    locked = 1'b1;
    rdy_mode = 0;
    tick();

    // Lock loss during POST
    post_a = 9'd4;
    arm(1'b0);
    retire(32'h50, 32'h50, 1'b1);
    retire(32'h54, 32'h54, 1'b0);
    chk_eq("abort_in_post", state_a, 2);
    locked = 1'b0;
    retire(32'h58, 32'h58, 1'b0);
    chk_eq("abort_state", state_a, 0);
    chk_eq("abort_valid", if_a.rd_valid_o, 0);
    chk_eq("abort_trig_kept", trig_a, 1);
    locked = 1'b1;
    tick();
    arm(1'b0);
    chk_eq("rearm_state", state_a, 1);
    chk_eq("rearm_trig_clr", trig_a, 0);
    locked = 1'b0;
    tick();
    chk_eq("abort_armed", state_a, 0);
    locked = 1'b1;
    tick();

`ifdef TRACE_TIMESTAMP_EN
    begin
      int k0, target;
      logic [15:0] t0;
      post_a = 9'd1;
      arm(1'b0);
      push_exp(1'b0, 32'h77, 1'b1);
      k0 = cyc;
      retire(32'h70, 32'h77, 1'b1);
      wait_idle("ts_cal", 1'b0);
      t0 = ts_seen_a;
      post_a = 9'd3;
      arm(1'b0);
      target = k0 + int'(16'(16'hFFFE - t0));
      while (target <= cyc + 1) target += 65536;
      while (cyc < target) tick();
      push_exp(1'b0, 32'd1, 1'b0, 16'hFFFE, 1'b1);
      push_exp(1'b0, 32'd2, 1'b0, 16'h0001, 1'b1);
      push_exp(1'b0, 32'd3, 1'b1, 16'h0002, 1'b1);
      retire(32'h80, 32'd1, 1'b1);
      tick();
      tick();
      retire(32'h84, 32'd2, 1'b0);
      retire(32'h88, 32'd3, 1'b0);
      wait_idle("ts", 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
